int_sequencer: RTL and testbench

INT_SEQUENCER -- requirements
Module: int_sequencer

---
 rtl/int_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_int_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_sequencer.sv
// int_sequencer: interrupt entry sequencer for an 8-bit CPU core.
//
// When control signals an instruction boundary and an interrupt is pending, the
// sequencer takes over the memory bus for five cycles. It pushes PCH, PCL and P
// (B = 0, bit 5 = 1) onto the stack page, then fetches the 16-bit vector. In the
// final cycle it loads the PC, loads S, sets the I flag, and acknowledges the
// IRQ channel that was taken.
//
// Optional feature macro: INT_SEQ_NMI_EN
//   defined   : falling-edge NMI detection; NMI has priority over every IRQ.
//   undefined : nmi_n is ignored and no NMI logic exists.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   irq_req, irq_mask  level IRQ requests and per-channel mask (1 = masked)
//   nmi_n              NMI request, falling-edge sensitive
//   i_flag             P[2]; blocks IRQs (not NMI) when set
//   instr_boundary     one-cycle fetch-boundary pulse from control
//   pc_in, p_in, sp_in current PC, P and S, sampled on accept
//   mem_rdata          read data, valid in the same cycle as mem_addr
//   mem_addr, mem_wdata, mem_rw   bus request (mem_rw: 1 = read, 0 = write)
//   busy               high in every cycle of the sequence
//   pc_out/pc_ld, sp_out/sp_ld, set_i   register-file updates, final cycle only
//   irq_ack            one-hot acknowledge of the IRQ channel taken
module int_sequencer #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = 16'hFFFE,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               nmi_n,
    input  logic               i_flag,
    input  logic               instr_boundary,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         p_in,
    input  logic [7:0]         sp_in,
    input  logic [7:0]         mem_rdata,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_rw,
    output logic               busy,
    output logic [15:0]        pc_out,
    output logic               pc_ld,
    output logic [7:0]         sp_out,
    output logic               sp_ld,
    output logic               set_i,
    output logic [NUM_IRQ-1:0] irq_ack
);

    typedef enum logic [2:0] {
        StIdle,
        StPushPch,
        StPushPcl,
        StPushP,
        StVecLo,
        StVecHi
    } state_e;

    state_e state_q;

    // Context latched on accept; sp_q always holds the next push address.
    logic [15:0]        pc_q;
    logic [7:0]         p_q;
    logic [7:0]         sp_q;
    logic [15:0]        vec_q;
    logic [NUM_IRQ-1:0] ack_src_q;
    logic [7:0]         vec_lo_q;

    // Registered outputs.
    logic [15:0]        mem_addr_q;
    logic [7:0]         mem_wdata_q;
    logic               mem_rw_q;
    logic               busy_q;
    logic               pc_ld_q;
    logic [7:0]         sp_out_q;
    logic               sp_ld_q;
    logic               set_i_q;
    logic [NUM_IRQ-1:0] irq_ack_q;

    logic [NUM_IRQ-1:0] irq_active;
    logic [2:0]         irq_idx;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [15:0]        irq_vec;
    logic               irq_pending;
    logic               nmi_pending;
    logic               pending;
    logic               accept;

    assign irq_active = irq_req & ~irq_mask;

    // Lowest asserted unmasked channel wins: scan downward so lower indices overwrite.
    always_comb begin
        irq_idx = 3'd0;
        for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
            if (irq_active[k]) begin
                irq_idx = 3'(k);
            end
        end
    end

    always_comb begin
        irq_onehot = '0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            irq_onehot[k] = (irq_idx == 3'(k));
        end
    end

    // Channel k vectors through VEC_BASE - 2*k.
    assign irq_vec     = VEC_BASE - {12'd0, irq_idx, 1'b0};
    assign irq_pending = ~i_flag & (|irq_active);
    assign pending     = nmi_pending | irq_pending;
    assign accept      = (state_q == StIdle) & instr_boundary & pending;

`ifdef INT_SEQ_NMI_EN
    logic nmi_prev_q;
    logic nmi_pending_q;
    logic nmi_pending_d;
    logic nmi_fall;

    assign nmi_fall = nmi_prev_q & ~nmi_n;
    // NMI always wins when pending, so any accept consumes it; a new edge in the
    // same cycle re-arms it for the following boundary.
    assign nmi_pending_d = (nmi_pending_q & ~accept) | nmi_fall;
    assign nmi_pending   = nmi_pending_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmi_prev_q    <= 1'b1;
            nmi_pending_q <= 1'b0;
        end else begin
            nmi_prev_q    <= nmi_n;
            nmi_pending_q <= nmi_pending_d;
        end
    end
`else
    logic unused_nmi_n;
    assign unused_nmi_n = nmi_n;
    assign nmi_pending  = 1'b0;
`endif

    // Outputs are registered: each branch loads the values for the state it enters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            p_q         <= '0;
            sp_q        <= '0;
            vec_q       <= '0;
            ack_src_q   <= '0;
            vec_lo_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b1;
            busy_q      <= 1'b0;
            pc_ld_q     <= 1'b0;
            sp_out_q    <= '0;
            sp_ld_q     <= 1'b0;
            set_i_q     <= 1'b0;
            irq_ack_q   <= '0;
        end else begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b1;
            pc_ld_q     <= 1'b0;
            sp_out_q    <= '0;
            sp_ld_q     <= 1'b0;
            set_i_q     <= 1'b0;
            irq_ack_q   <= '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StPushPch;
                        busy_q      <= 1'b1;
                        pc_q        <= pc_in;
                        // Pushed P carries B = 0 and the always-one bit 5.
                        p_q         <= (p_in & 8'hEF) | 8'h20;
                        sp_q        <= sp_in - 8'd1;
                        vec_q       <= nmi_pending ? NMI_VEC : irq_vec;
                        ack_src_q   <= nmi_pending ? '0 : irq_onehot;
                        mem_addr_q  <= {STACK_PAGE, sp_in};
                        mem_wdata_q <= pc_in[15:8];
                        mem_rw_q    <= 1'b0;
                    end
                end
                StPushPch: begin
                    state_q     <= StPushPcl;
                    mem_addr_q  <= {STACK_PAGE, sp_q};
                    mem_wdata_q <= pc_q[7:0];
                    mem_rw_q    <= 1'b0;
                    sp_q        <= sp_q - 8'd1;
                end
                StPushPcl: begin
                    state_q     <= StPushP;
                    mem_addr_q  <= {STACK_PAGE, sp_q};
                    mem_wdata_q <= p_q;
                    mem_rw_q    <= 1'b0;
                    sp_q        <= sp_q - 8'd1;
                end
                StPushP: begin
                    state_q    <= StVecLo;
                    mem_addr_q <= vec_q;
                end
                StVecLo: begin
                    state_q    <= StVecHi;
                    vec_lo_q   <= mem_rdata;
                    mem_addr_q <= vec_q + 16'd1;
                    pc_ld_q    <= 1'b1;
                    sp_ld_q    <= 1'b1;
                    set_i_q    <= 1'b1;
                    sp_out_q   <= sp_q;
                    irq_ack_q  <= ack_src_q;
                end
                StVecHi: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rw    = mem_rw_q;
    assign busy      = busy_q;
    // High vector byte arrives in the same cycle it is addressed.
    assign pc_out    = pc_ld_q ? {mem_rdata, vec_lo_q} : 16'h0000;
    assign pc_ld     = pc_ld_q;
    assign sp_out    = sp_out_q;
    assign sp_ld     = sp_ld_q;
    assign set_i     = set_i_q;
    assign irq_ack   = irq_ack_q;

endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: self-checking bench for int_sequencer (NUM_IRQ = 4, default vectors).
// Expected bus activity is computed from the interrupt-entry rules: three stack
// pushes, two vector reads, then the register-file update in the fifth cycle.
module tb_int_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_req;
    logic [3:0]  irq_mask;
    logic        nmi_n;
    logic        i_flag;
    logic        instr_boundary;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic [7:0]  sp_in;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rw;
    logic        busy;
    logic [15:0] pc_out;
    logic        pc_ld;
    logic [7:0]  sp_out;
    logic        sp_ld;
    logic        set_i;
    logic [3:0]  irq_ack;

    int_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_req        (irq_req),
        .irq_mask       (irq_mask),
        .nmi_n          (nmi_n),
        .i_flag         (i_flag),
        .instr_boundary (instr_boundary),
        .pc_in          (pc_in),
        .p_in           (p_in),
        .sp_in          (sp_in),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rw         (mem_rw),
        .busy           (busy),
        .pc_out         (pc_out),
        .pc_ld          (pc_ld),
        .sp_out         (sp_out),
        .sp_ld          (sp_ld),
        .set_i          (set_i),
        .irq_ack        (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        mem_rw;
        logic [15:0] mem_addr;
        logic [7:0]  mem_wdata;
        logic        pc_ld;
        logic [15:0] pc_out;
        logic        sp_ld;
        logic [7:0]  sp_out;
        logic        set_i;
        logic [3:0]  irq_ack;
    } outs_t;

    outs_t obs;
    outs_t exp_o;
    assign obs = {busy, mem_rw, mem_addr, mem_wdata, pc_ld, pc_out, sp_ld, sp_out, set_i, irq_ack};

    int n_tests;
    int n_fail;

    // Vector ROM: every vector lives in FFF0..FFFF, so the low nibble selects it.
    logic [7:0] vtab [16];
    assign mem_rdata = vtab[mem_addr[3:0]];

    // Source selection: -1 = NMI, -2 = nothing pending, k = IRQ channel k.
    function automatic int pick(input logic [3:0] irq, input logic [3:0] mask,
                                input logic iflag, input logic nmi);
        if (nmi) return -1;
        if (iflag) return -2;
        for (int k = 0; k < 4; k++) begin
            if (irq[k] && !mask[k]) return k;
        end
        return -2;
    endfunction

    // Expected outputs in cycle cyc (1..5) after the accept edge; anything else is idle.
    function automatic outs_t model_out(input logic [15:0] pc, input logic [7:0] p,
                                        input logic [7:0] sp, input int src, input int cyc);
        outs_t       e;
        logic [15:0] vec;
        logic [15:0] vec1;
        logic [7:0]  pushed [3];
        e        = '0;
        e.mem_rw = 1'b1;
        if (cyc < 1 || cyc > 5) return e;
        vec       = (src == -1) ? 16'hFFFA : 16'hFFFE - 16'(2 * src);
        vec1      = vec + 16'd1;
        pushed[0] = pc[15:8];
        pushed[1] = pc[7:0];
        pushed[2] = {p[7:6], 2'b10, p[3:0]};
        e.busy    = 1'b1;
        if (cyc <= 3) begin
            e.mem_rw    = 1'b0;
            e.mem_addr  = {8'h01, sp - 8'(cyc - 1)};
            e.mem_wdata = pushed[cyc - 1];
        end else if (cyc == 4) begin
            e.mem_addr = vec;
        end else begin
            e.mem_addr = vec1;
            e.pc_ld    = 1'b1;
            e.pc_out   = {vtab[vec1[3:0]], vtab[vec[3:0]]};
            e.sp_ld    = 1'b1;
            e.sp_out   = sp - 8'd3;
            e.set_i    = 1'b1;
            e.irq_ack  = (src >= 0) ? 4'(1 << src) : 4'b0000;
        end
        return e;
    endfunction

    // Present one boundary pulse at the current negedge; return at the next negedge.
    task automatic pulse(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                         input logic [3:0] irq, input logic [3:0] mask, input logic iflag);
        pc_in          = pc;
        p_in           = p;
        sp_in          = sp;
        irq_req        = irq;
        irq_mask       = mask;
        i_flag         = iflag;
        instr_boundary = 1'b1;
        @(negedge clk);
        instr_boundary = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_boundary = 1'b1;
            irq_req        = 4'($urandom);
            irq_mask       = 4'b0000;
            i_flag         = 1'b0;
            pc_in          = 16'($urandom);
            sp_in          = 8'($urandom);
            @(negedge clk);
            exp_o = model_out(16'h0, 8'h0, 8'h0, -2, 0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h, expected %h", i, obs, exp_o);
            end
        end
        instr_boundary = 1'b0;
        irq_req        = 4'b0000;
        rst_n          = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_irq();
        logic [15:0] ea [5];
        logic [7:0]  ew [5];
        ea = '{16'h01FD, 16'h01FC, 16'h01FB, 16'hFFFA, 16'hFFFB};
        ew = '{8'hC1, 8'h23, 8'h20, 8'h00, 8'h00};
        pulse(16'hC123, 8'h30, 8'hFD, 4'b0100, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (mem_addr !== ea[c] || mem_wdata !== ew[c] || mem_rw !== (c >= 3) ||
                busy !== 1'b1 || pc_ld !== (c == 4)) begin
                n_fail++;
                $display("FAIL basic_bus[%0d]: got addr=%h wdata=%h rw=%b busy=%b pc_ld=%b, expected addr=%h wdata=%h rw=%b busy=1 pc_ld=%b",
                         c, mem_addr, mem_wdata, mem_rw, busy, pc_ld, ea[c], ew[c], c >= 3, c == 4);
            end
            if (c == 4) begin
                n_tests++;
                if (pc_out !== {vtab[4'hB], vtab[4'hA]} || sp_out !== 8'hFA || sp_ld !== 1'b1 ||
                    set_i !== 1'b1 || irq_ack !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL basic_final: got pc=%h sp=%h sp_ld=%b set_i=%b ack=%b, expected pc=%h sp=fa sp_ld=1 set_i=1 ack=0100",
                             pc_out, sp_out, sp_ld, set_i, irq_ack, {vtab[4'hB], vtab[4'hA]});
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b0 || pc_ld !== 1'b0 || irq_ack !== 4'b0000 || mem_rw !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got busy=%b pc_ld=%b ack=%b rw=%b, expected 0 0 0000 1",
                     busy, pc_ld, irq_ack, mem_rw);
        end
        irq_req = 4'b0000;
    endtask

    task automatic test_iflag();
        pulse(16'h1234, 8'h04, 8'hFF, 4'b0011, 4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            exp_o = model_out(16'h0, 8'h0, 8'h0, -2, 0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL iflag_block[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            @(negedge clk);
        end
        pulse(16'h1234, 8'h04, 8'hFF, 4'b0011, 4'b0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            exp_o = model_out(16'h1234, 8'h04, 8'hFF, 0, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL iflag_take[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            if (c == 4) begin
                n_tests++;
                if (mem_addr !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL iflag_vector: got %h, expected fffe", mem_addr);
                end
            end
            @(negedge clk);
        end
        irq_req = 4'b0000;
    endtask

    task automatic test_sp_wrap();
        logic [15:0] ea [3];
        ea = '{16'h0101, 16'h0100, 16'h01FF};
        pulse(16'h8001, 8'hFF, 8'h01, 4'b1000, 4'b0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            exp_o = model_out(16'h8001, 8'hFF, 8'h01, 3, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL sp_wrap[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            if (c <= 3) begin
                n_tests++;
                if (mem_addr !== ea[c - 1]) begin
                    n_fail++;
                    $display("FAIL sp_wrap_addr[%0d]: got %h, expected %h", c, mem_addr, ea[c - 1]);
                end
            end else if (c == 5) begin
                n_tests++;
                if (sp_out !== 8'hFE) begin
                    n_fail++;
                    $display("FAIL sp_wrap_out: got %h, expected fe", sp_out);
                end
            end
            @(negedge clk);
        end
        irq_req = 4'b0000;
    endtask

`ifdef INT_SEQ_NMI_EN
    task automatic test_nmi();
        nmi_n = 1'b1;
        @(negedge clk);
        nmi_n = 1'b0;
        @(negedge clk);
        // NMI and IRQ0 both pending at this boundary: NMI wins, no acknowledge.
        pulse(16'hABCD, 8'hFF, 8'h80, 4'b0001, 4'b0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            exp_o = model_out(16'hABCD, 8'hFF, 8'h80, -1, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL nmi_first[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            @(negedge clk);
        end
        // IRQ0 follows at the next boundary; an NMI edge arrives while busy.
        pulse(16'h0102, 8'h00, 8'h40, 4'b0001, 4'b0000, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            exp_o = model_out(16'h0102, 8'h00, 8'h40, 0, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL nmi_then_irq[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            if (c == 2) nmi_n = 1'b1;
            if (c == 3) nmi_n = 1'b0;
            @(negedge clk);
        end
        // Edge seen during busy is taken now, even with I set and IRQs masked.
        pulse(16'h5555, 8'h04, 8'h20, 4'b0001, 4'b1111, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            exp_o = model_out(16'h5555, 8'h04, 8'h20, -1, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL nmi_rearm[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            @(negedge clk);
        end
        nmi_n   = 1'b1;
        irq_req = 4'b0000;
    endtask
`else
    task automatic test_nmi();
        nmi_n = 1'b1;
        @(negedge clk);
        nmi_n = 1'b0;
        @(negedge clk);
        pulse(16'hABCD, 8'hFF, 8'h80, 4'b0001, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            exp_o = model_out(16'h0, 8'h0, 8'h0, -2, 0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL nmi_ignored[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            @(negedge clk);
        end
        nmi_n   = 1'b1;
        irq_req = 4'b0000;
    endtask
`endif

    task automatic test_reset_mid();
        pulse(16'h2468, 8'h00, 8'hF0, 4'b1000, 4'b0000, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            exp_o = model_out(16'h2468, 8'h00, 8'hF0, 3, c);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_pre[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            if (c == 2) begin
                rst_n          = 1'b0;
                instr_boundary = 1'b1;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            exp_o = model_out(16'h0, 8'h0, 8'h0, -2, 0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_after[%0d]: got %h, expected %h", c, obs, exp_o);
            end
            if (c == 1) begin
                rst_n          = 1'b1;
                instr_boundary = 1'b0;
            end
            @(negedge clk);
        end
        irq_req = 4'b0000;
    endtask

    // Random contexts, back-to-back entries, and input churn (including boundary
    // pulses and IRQ/mask changes) while the sequence is running.
    task automatic test_random();
        logic [15:0] pc;
        logic [7:0]  p;
        logic [7:0]  sp;
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        iflag;
        int          src;
        int          ncyc;
        nmi_n = 1'b1;
        for (int t = 0; t < 40; t++) begin
            pc    = 16'($urandom);
            p     = 8'($urandom);
            sp    = 8'($urandom);
            irq   = 4'($urandom);
            mask  = 4'($urandom);
            iflag = ($urandom_range(0, 3) == 0);
`ifndef INT_SEQ_NMI_EN
            nmi_n = 1'($urandom);
`endif
            src  = pick(irq, mask, iflag, 1'b0);
            ncyc = (src == -2) ? 1 : 5;
            pulse(pc, p, sp, irq, mask, iflag);
            for (int c = 1; c <= ncyc; c++) begin
                exp_o = model_out(pc, p, sp, src, (src == -2) ? 0 : c);
                n_tests++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL random[%0d.%0d]: got %h, expected %h", t, c, obs, exp_o);
                end
                if (src != -2) begin
                    instr_boundary = 1'($urandom);
                    irq_req        = 4'($urandom);
                    irq_mask       = 4'($urandom);
                    i_flag         = 1'($urandom);
                    pc_in          = 16'($urandom);
                    sp_in          = 8'($urandom);
                end
                if (src != -2 || c < ncyc) @(negedge clk);
            end
        end
        instr_boundary = 1'b0;
        @(negedge clk);
        exp_o = model_out(16'h0, 8'h0, 8'h0, -2, 0);
        n_tests++;
        if (obs !== exp_o) begin
            n_fail++;
            $display("FAIL random_end: got %h, expected %h", obs, exp_o);
        end
        nmi_n = 1'b1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        irq_req        = 4'b0000;
        irq_mask       = 4'b0000;
        nmi_n          = 1'b1;
        i_flag         = 1'b0;
        instr_boundary = 1'b0;
        pc_in          = 16'h0000;
        p_in           = 8'h00;
        sp_in          = 8'h00;
        for (int i = 0; i < 16; i++) vtab[i] = 8'($urandom);
        test_reset();
        test_basic_irq();
        test_iflag();
        test_sp_wrap();
        test_nmi();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
